// File: rtl/onewire_defs.sv
// Shared definitions for the 1-Wire master: opcodes, FSM state codes, default slot timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package onewire_defs;

    // Host command opcodes; 5..7 are reserved and complete with no bus activity
    localparam logic [2:0] OP_RESET      = 3'd0;
    localparam logic [2:0] OP_WRITE_BYTE = 3'd1;
    localparam logic [2:0] OP_READ_BYTE  = 3'd2;
    localparam logic [2:0] OP_WRITE_BIT  = 3'd3;
    localparam logic [2:0] OP_READ_BIT   = 3'd4;

    // FSM state encodings
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RST_LOW  = 3'd2;
    localparam logic [2:0] S_RST_REL  = 3'd3;
    localparam logic [2:0] S_SLOT_LOW = 3'd4;
    localparam logic [2:0] S_SLOT_REL = 3'd5;
    localparam logic [2:0] S_SLOT_REC = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // Standard-speed timing defaults (microseconds unless noted)
    localparam int DEF_CLK_PER_US = 50;
    localparam int DEF_T_RSTL     = 480;
    localparam int DEF_T_PDS      = 70;
    localparam int DEF_T_RSTH     = 480;
    localparam int DEF_T_SLOT     = 60;
    localparam int DEF_T_LOW1     = 6;
    localparam int DEF_T_RDS      = 15;
    localparam int DEF_T_REC      = 2;

    // Microsecond phase timer width; covers the 480 us reset phases
    localparam int TMR_W = 10;

    // Response register contents
    typedef struct packed {
        logic [7:0] data;
        logic       presence;
    } rsp_t;

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_READ_BYTE) || (op == OP_READ_BIT);
    endfunction

    function automatic logic op_is_byte(input logic [2:0] op);
        return (op == OP_WRITE_BYTE) || (op == OP_READ_BYTE);
    endfunction

    function automatic logic op_is_slot(input logic [2:0] op);
        return op inside {OP_WRITE_BYTE, OP_READ_BYTE, OP_WRITE_BIT, OP_READ_BIT};
    endfunction

endpackage

// File: rtl/onewire_tick.sv
// Microsecond prescaler: counts 0..CLK_PER_US-1 and flags the wrap cycle as o_us_tick.
// Latency: first tick CLK_PER_US cycles after i_clr drops; then one tick every CLK_PER_US cycles.
// Backpressure: none; i_clr holds the count at 0 for as long as it is asserted.
// Ports: clk, rst (sync, active-high), i_clr (hold/restart), o_us_tick (one-cycle wrap flag).
module onewire_tick
    import onewire_defs::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_us_tick
);

    localparam int            CW     = $clog2(CLK_PER_US);
    localparam logic [CW-1:0] L_LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == L_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_us_tick = (r_cnt == L_LAST);

endmodule

// File: rtl/onewire_master.sv
// Byte/bit-level 1-Wire master: reset/presence, write and read slots on an open-drain DQ pad.
// Latency: accept -> 1-cycle load -> bus phases (exact multiples of CLK_PER_US) -> 1-cycle rsp_valid.
// Backpressure: cmd_ready low from the cycle after acceptance until the cycle after rsp_valid.
// Ports: clk/rst; cmd_valid/cmd_ready/cmd_op/cmd_data in; rsp_valid/rsp_data/rsp_presence/busy out;
//        dq_out/dq_ena to the pad (low = ena&!out), dq_in asynchronous bus level from the pad.
module onewire_master
    import onewire_defs::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int T_RSTL     = DEF_T_RSTL,
    parameter int T_PDS      = DEF_T_PDS,
    parameter int T_RSTH     = DEF_T_RSTH,
    parameter int T_SLOT     = DEF_T_SLOT,
    parameter int T_LOW1     = DEF_T_LOW1,
    parameter int T_RDS      = DEF_T_RDS,
    parameter int T_REC      = DEF_T_REC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       busy,
    output logic       dq_out,
    output logic       dq_ena,
    input  logic       dq_in
);

    // Timer compare values: a phase of N us ends on the tick seen while the timer reads N-1
    localparam logic [TMR_W-1:0] L_RSTL = TMR_W'(T_RSTL - 1);
    localparam logic [TMR_W-1:0] L_PDS  = TMR_W'(T_PDS - 1);
    localparam logic [TMR_W-1:0] L_RSTH = TMR_W'(T_RSTH - 1);
    localparam logic [TMR_W-1:0] L_SLOT = TMR_W'(T_SLOT - 1);
    localparam logic [TMR_W-1:0] L_LOW1 = TMR_W'(T_LOW1 - 1);
    localparam logic [TMR_W-1:0] L_RDS  = TMR_W'(T_RDS - 1);
    localparam logic [TMR_W-1:0] L_REC  = TMR_W'(T_REC - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [2:0]       r_op;
    logic [7:0]       r_sr;
    logic [3:0]       r_bits;
    logic [TMR_W-1:0] r_us;
    logic             r_dq_meta;
    logic             r_dq_sync;
    logic             r_pres;
    logic             r_ready;
    logic             r_rsp_valid;
    logic             r_dq_ena;
    rsp_t             r_rsp;

    logic w_us_tick;
    logic w_clr;
    logic w_accept;
    logic w_read;
    logic w_long_low;
    logic w_low_end;
    logic w_keep_timer;

    // Prescaler sits at 0 outside timed phases so every phase starts on a fresh microsecond
    assign w_clr = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);

    onewire_tick #(
        .CLK_PER_US (CLK_PER_US)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .o_us_tick (w_us_tick)
    );

    assign w_accept   = cmd_valid && r_ready;
    assign w_read     = op_is_read(r_op);
    // Only a written 0 holds the bus for the whole slot; write-1 and read use the short pulse
    assign w_long_low = !w_read && !r_sr[0];
    assign w_low_end  = w_us_tick && (r_us == (w_long_low ? L_SLOT : L_LOW1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (r_op == OP_RESET)      w_next = S_RST_LOW;
                else if (op_is_slot(r_op)) w_next = S_SLOT_LOW;
                else                       w_next = S_DONE;
            end
            S_RST_LOW: begin
                if (w_us_tick && (r_us == L_RSTL)) w_next = S_RST_REL;
            end
            S_RST_REL: begin
                if (w_us_tick && (r_us == L_RSTH)) w_next = S_DONE;
            end
            S_SLOT_LOW: begin
                // A full-length low already spans the slot, so the release phase is skipped
                if (w_low_end) w_next = w_long_low ? S_SLOT_REC : S_SLOT_REL;
            end
            S_SLOT_REL: begin
                if (w_us_tick && (r_us == L_SLOT)) w_next = S_SLOT_REC;
            end
            S_SLOT_REC: begin
                if (w_us_tick && (r_us == L_REC)) w_next = (r_bits == 4'd1) ? S_DONE : S_SLOT_LOW;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Slot timing is measured from the falling edge, so the timer runs on across LOW -> REL
    assign w_keep_timer = (r_state == S_SLOT_LOW) && (w_next == S_SLOT_REL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_us <= '0;
        end else if ((w_next != r_state) && !w_keep_timer) begin
            r_us <= '0;
        end else if (w_us_tick) begin
            r_us <= r_us + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dq_meta   <= 1'b1;
            r_dq_sync   <= 1'b1;
            r_state     <= S_IDLE;
            r_op        <= OP_RESET;
            r_sr        <= '0;
            r_bits      <= '0;
            r_pres      <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_dq_ena    <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_dq_meta   <= dq_in;
            r_dq_sync   <= r_dq_meta;
            r_state     <= w_next;
            r_ready     <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_DONE);
            r_dq_ena    <= (w_next == S_RST_LOW) || (w_next == S_SLOT_LOW);

            if (w_accept) begin
                r_op   <= cmd_op;
                r_sr   <= cmd_data;
                r_pres <= 1'b0;
                r_rsp  <= '0;
            end

            if (r_state == S_LOAD) begin
                r_bits <= op_is_byte(r_op) ? 4'd8 : 4'd1;
            end

            if ((r_state == S_RST_REL) && w_us_tick && (r_us == L_PDS)) begin
                r_pres <= !r_dq_sync;
            end

            // Read bits enter at bit7, so after 8 slots the first bit sits in bit0
            if ((r_state == S_SLOT_REL) && w_us_tick && (r_us == L_RDS) && w_read) begin
                r_sr <= {r_dq_sync, r_sr[7:1]};
            end

            if ((r_state == S_SLOT_REC) && w_us_tick && (r_us == L_REC)) begin
                r_bits <= r_bits - 4'd1;
                if (!w_read) r_sr <= {1'b0, r_sr[7:1]};
            end

            if (w_next == S_DONE) begin
                r_rsp.presence <= (r_op == OP_RESET) && r_pres;
                case (r_op)
                    OP_READ_BYTE: r_rsp.data <= r_sr;
                    OP_READ_BIT:  r_rsp.data <= {7'd0, r_sr[7]};
                    default:      r_rsp.data <= '0;
                endcase
            end
        end
    end

    assign cmd_ready    = r_ready;
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp.data;
    assign rsp_presence = r_rsp.presence;
    assign dq_ena       = r_dq_ena;
    assign dq_out       = !r_dq_ena;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at 4 clocks/us with a behavioural slave on a pulled-up wire.
// Latency: n/a.
// Backpressure: n/a.
module tb_onewire_master;

    localparam int CPU = 4;
    localparam int PER = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_presence, busy, dq_out, dq_ena, dq_in;
    logic [7:0] rsp_data;

    always #5 clk = ~clk;

    onewire_master #(.CLK_PER_US(CPU)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_presence (rsp_presence),
        .busy         (busy),
        .dq_out       (dq_out),
        .dq_ena       (dq_ena),
        .dq_in        (dq_in)
    );

    // Wired-AND bus with pull-up
    logic       pull_pres = 1'b0;
    logic       pull_read = 1'b0;
    logic       pull_hold = 1'b0;
    logic [1:0] slave_mode = 2'd0;
    logic [7:0] rd_byte = 8'd0;
    logic [2:0] rd_idx = 3'd0;
    logic       rd_bit = 1'b1;
    logic       m_low;

    assign m_low = dq_ena & ~dq_out;
    assign dq_in = ~(m_low | pull_pres | pull_read | pull_hold);

    // Presence pulse 15..240 us after the master releases
    always @(negedge m_low) begin
        if (slave_mode == 2'd1) begin
            repeat (15 * CPU) @(posedge clk);
            pull_pres = 1'b1;
            repeat (225 * CPU) @(posedge clk);
            pull_pres = 1'b0;
        end
    end

    // Read slave: returns rd_byte LSB first, a 0 is held low for 30 us from the falling edge
    always @(posedge m_low) begin
        if (slave_mode == 2'd2) begin
            rd_bit = rd_byte[rd_idx];
            rd_idx = rd_idx + 3'd1;
            if (!rd_bit) begin
                pull_read = 1'b1;
                repeat (30 * CPU) @(posedge clk);
                pull_read = 1'b0;
            end
        end else begin
            rd_idx = 3'd0;
        end
    end

    // Bus monitor
    int   ena_rises = 0;
    int   rv_count = 0;
    int   ill_cnt = 0;
    int   low_cnt = 0;
    logic prev_ena = 1'b0;
    time  t_fall = 0;
    int   widths[$];
    time  starts[$];

    always @(negedge clk) begin
        if (dq_ena && dq_out) ill_cnt++;
        if (rsp_valid) rv_count++;
        if (dq_ena && !prev_ena) begin
            ena_rises++;
            starts.push_back($time);
            low_cnt = 0;
        end
        if (dq_ena) low_cnt++;
        if (!dq_ena && prev_ena) begin
            widths.push_back(low_cnt);
            t_fall = $time;
        end
        prev_ena = dq_ena;
    end

    int  checks = 0;
    int  errors = 0;
    time t_acc = 0;
    time t_rv = 0;
    int  exp_w[8] = '{24, 240, 24, 240, 240, 24, 240, 24};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] d, input string tag);
        int n;
        @(negedge clk);
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(cmd_ready), 1);
        t_acc = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 1);
        t_rv = $time;
    endtask

    initial begin
        int   w0, s0, e0, rc, n, bad;
        time  ta;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dq_ena", 32'(dq_ena), 0);
        chk("rst_dq_out", 32'(dq_out), 1);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_presence", 32'(rsp_presence), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);

        // RESET with a slave answering presence
        slave_mode = 2'd1;
        w0 = widths.size();
        send(3'd0, 8'h00, "rstp");
        chk("rstp_busy", 32'(busy), 1);
        chk("rstp_ready_low", 32'(cmd_ready), 0);
        wait_rsp("rstp", 5000);
        chk("rstp_low_width", 32'(widths[w0]), 1920);
        chk("rstp_rel_to_rsp", 32'(int'((t_rv - t_fall) / PER)), 1920);
        chk("rstp_total_ge_3840", 32'(int'((t_rv - t_acc) / PER) >= 3840), 1);
        chk("rstp_presence", 32'(rsp_presence), 1);
        chk("rstp_data", 32'(rsp_data), 0);
        @(negedge clk);
        chk("rstp_valid_pulse", 32'(rsp_valid), 0);
        chk("rstp_presence_held", 32'(rsp_presence), 1);
        chk("rstp_ready_back", 32'(cmd_ready), 1);
        slave_mode = 2'd0;

        // RESET with no slave
        w0 = widths.size();
        send(3'd0, 8'h00, "rstn");
        wait_rsp("rstn", 5000);
        chk("rstn_low_width", 32'(widths[w0]), 1920);
        chk("rstn_rel_to_rsp", 32'(int'((t_rv - t_fall) / PER)), 1920);
        chk("rstn_presence", 32'(rsp_presence), 0);

        // WRITE_BYTE 0xA5
        w0 = widths.size();
        s0 = starts.size();
        send(3'd1, 8'hA5, "wr");
        chk("wr_busy", 32'(busy), 1);
        wait_rsp("wr", 3000);
        chk("wr_slot_count", 32'(widths.size() - w0), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wr_low%0d", i), 32'(widths[w0 + i]), 32'(exp_w[i]));
        end
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("wr_period%0d", i), 32'(int'((starts[s0 + i] - starts[s0 + i - 1]) / PER)), 248);
        end
        chk("wr_data", 32'(rsp_data), 0);
        chk("wr_presence", 32'(rsp_presence), 0);

        // READ_BYTE, slave returns 0x3C
        rd_byte = 8'h3C;
        slave_mode = 2'd2;
        w0 = widths.size();
        send(3'd2, 8'h00, "rd");
        wait_rsp("rd", 3000);
        chk("rd_slot_count", 32'(widths.size() - w0), 8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (widths[w0 + i] != 24) bad++;
        end
        chk("rd_low_widths_bad", 32'(bad), 0);
        chk("rd_data", 32'(rsp_data), 32'h3C);
        @(negedge clk);
        chk("rd_data_held", 32'(rsp_data), 32'h3C);
        slave_mode = 2'd0;

        // READ_BIT, bus held low then released
        pull_hold = 1'b1;
        send(3'd4, 8'h00, "rb0");
        wait_rsp("rb0", 600);
        chk("rb0_data", 32'(rsp_data), 32'h00);
        pull_hold = 1'b0;
        send(3'd4, 8'h00, "rb1");
        wait_rsp("rb1", 600);
        chk("rb1_data", 32'(rsp_data), 32'h01);

        // Back-to-back reserved opcodes with cmd_valid held high
        e0 = ena_rises;
        @(negedge clk);
        cmd_op    = 3'd6;
        cmd_data  = 8'hFF;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ta = $time;
        @(negedge clk);
        cmd_op = 3'd7;
        wait_rsp("rsv1", 10);
        chk("rsv1_latency", 32'(int'((t_rv - ta) / PER)), 2);
        chk("rsv1_data", 32'(rsp_data), 0);
        chk("rsv1_presence", 32'(rsp_presence), 0);
        @(negedge clk);
        chk("rsv2_accept_next", 32'(cmd_ready), 1);
        ta = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rsv2_busy", 32'(busy), 1);
        wait_rsp("rsv2", 10);
        chk("rsv2_latency", 32'(int'((t_rv - ta) / PER)), 2);
        chk("rsv_no_bus", 32'(ena_rises - e0), 0);

        // Reset in the middle of a WRITE_BYTE while the bus is low
        send(3'd1, 8'h00, "abort");
        n = 0;
        while (dq_ena !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_bus_low", 32'(dq_ena), 1);
        repeat (50) @(negedge clk);
        rc = rv_count;
        e0 = ena_rises;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_dq_ena", 32'(dq_ena), 0);
        chk("abort_dq_out", 32'(dq_out), 1);
        chk("abort_ready_in_rst", 32'(cmd_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(cmd_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        repeat (2500) @(negedge clk);
        chk("abort_no_rsp", 32'(rv_count - rc), 0);
        chk("abort_no_bus", 32'(ena_rises - e0), 0);

        chk("never_ena_with_out_high", 32'(ill_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onewire_master.md
Name: onewire_master

Overview:
Byte-level 1-Wire bus master that sequences the open-drain DQ pad primitive (dq_out/dq_ena/dq_in).
- Accepts reset/write/read commands from a host.
- Generates standard-speed slot timing from a microsecond prescaler.
- Returns read data and the presence-detect result.
- Sits between a CPU/register block and the DQ pad instance; it is the only driver of that pad.

Parameters:
CLK_PER_US, 50, clock cycles per microsecond (must be ≥2)
T_RSTL, 480, reset low time, us
T_PDS, 70, presence sample point after reset release, us
T_RSTH, 480, total release time after reset low, us (must be > T_PDS)
T_SLOT, 60, bit slot length from falling edge, us
T_LOW1, 6, low time for write-1 and for read initiation, us
T_RDS, 15, read sample point from slot start, us (T_LOW1 < T_RDS < T_SLOT)
T_REC, 2, released recovery time after each slot, us

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high when the block can accept a command
cmd_op  in  3  0=RESET, 1=WRITE_BYTE, 2=READ_BYTE, 3=WRITE_BIT, 4=READ_BIT, others reserved
cmd_data  in  8  write data; bit0 only for WRITE_BIT
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  8  read byte; bit0 for READ_BIT; 0 for other ops
rsp_presence  out  1  presence seen (RESET only; 0 otherwise)
busy  out  1  operation in progress
dq_out  out  1  to pad: 0 = pull low when enabled
dq_ena  out  1  to pad: drive enable
dq_in  in  1  from pad: asynchronous bus level

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. Clock port `clk`, reset port `rst`.
- Values while rst is sampled high (and held after it, until the next command):
  - dq_ena=0, dq_out=1 (bus released)
  - cmd_ready=0 during rst; cmd_ready=1 in IDLE afterwards
  - busy=0, rsp_valid=0, rsp_data=0, rsp_presence=0
- Reset mid-operation: abort immediately and release the bus on the same edge. No rsp_valid is produced for the aborted command.
- Bus drive:
  - Low = {dq_ena=1, dq_out=0}.
  - Release = {dq_ena=0, dq_out=1}.
  - Never dq_ena=1 with dq_out=1.
- dq_in goes through a 2-flop synchronizer before any use.
- Prescaler:
  - Counts 0..CLK_PER_US-1 and emits a us_tick on wrap.
  - Held at 0 in IDLE and restarted when each phase starts, so phase durations are exact: N us = N*CLK_PER_US cycles.
- Handshake:
  - A command is accepted on the cycle cmd_valid & cmd_ready.
  - cmd_op and cmd_data are registered at acceptance.
  - cmd_ready=0 and busy=1 from the next cycle until rsp_valid.
  - cmd_ready returns to 1 on the cycle after rsp_valid.
- States:
  - IDLE: waits for a command.
  - RST_LOW: drive low for T_RSTL us.
  - RST_REL: release for T_RSTH us. At T_PDS us, latch presence = !dq_sync.
  - SLOT_LOW: drive low. Duration is T_LOW1 for a 1 or a read, T_SLOT for a 0.
  - SLOT_REL: release until T_SLOT us from slot start. For reads, sample dq_sync at T_RDS us from slot start into the shift register.
  - SLOT_REC: release for T_REC us. Then, if bits remain, go to SLOT_LOW; otherwise go to DONE.
  - DONE: one cycle. Pulse rsp_valid and return to IDLE.
- Bit ordering:
  - Bytes are LSB first: 8 slots; single-bit ops: 1 slot.
  - Read bits shift in at bit7 and move toward bit0. After 8 reads, rsp_data[0] is the first bit read.
  - READ_BIT returns its value in rsp_data[0]; rsp_data[7:1]=0.
- Reserved opcodes: accepted, with no bus activity. Go to DONE the next cycle, with rsp_data=0 and rsp_presence=0.
- Response hold: rsp_data and rsp_presence are held stable from rsp_valid until the next acceptance.
- Timer: 10 bits, enough for 480. Compare with equality against the parameter minus one on us_tick.

Decomposition:
- Shared package onewire_defs:
  - opcode localparams OP_RESET..OP_READ_BIT
  - state encodings
  - default timing constants
- Sub-module onewire_tick: prescaler with start/clear input and us_tick output, parameter CLK_PER_US.
- Synchronizer and FSM stay in onewire_master.
- onewire_master connects directly to the existing DQ pad primitive.

Test Plan:
- Bench setup: CLK_PER_US=4, with a behavioural slave model on a pulled-up wire.
- RESET with slave pulling low during 15..240 us after release:
  - dq low for exactly 1920 cycles
  - rsp_presence=1
  - rsp_valid pulses 1920 cycles after release starts (total ≥3840 cycles)
- RESET with no slave -> rsp_presence=0, identical timing.
- WRITE_BYTE 0xA5:
  - slots carry the LSB-first pattern 1,0,1,0,0,1,0,1
  - low widths 24/240/24/240/240/24/240/24 cycles
  - each slot plus recovery = 248 cycles
  - rsp_data=0
- READ_BYTE with slave returning 0x3C:
  - each slot has a 24-cycle low pulse
  - rsp_data=0x3C
  - READ_BIT with slave holding low -> rsp_data=0x00; with bus released -> 0x01
- Back-to-back commands with cmd_valid held high:
  - second command accepted on the cycle after the first rsp_valid
  - cmd op=6 (reserved) -> rsp_valid two cycles after acceptance, no dq_ena activity
- rst asserted mid WRITE_BYTE while bus is low:
  - dq_ena=0 on the next edge
  - no rsp_valid
  - cmd_ready=1 the cycle after rst deasserts
